// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks every valid output position of the feature map,
// fetches each K_H x K_W window from a 1-cycle-latency SRAM and streams MAC results out.

module conv_unit #(
    parameter int K_H = 3,
    parameter int K_W = 3
) (
    input  logic [K_H*K_W*8-1:0] pix_flat,
    input  logic [K_H*K_W*8-1:0] w_flat,
    output logic [23:0]          result
);
    localparam int N = K_H * K_W;

    logic signed [16:0] prod_s [N];

    // Pixels are unsigned: widen with a zero MSB before the signed multiply.
    for (genvar i = 0; i < N; i++) begin : g_mac
        assign prod_s[i] = 17'($signed({1'b0, pix_flat[i*8 +: 8]})) * 17'($signed(w_flat[i*8 +: 8]));
    end

    // Sum all products, sign-extended to the result width
    always_comb begin
        result = 24'd0;
        for (int i = 0; i < N; i++) begin
            result = result + {{7{prod_s[i][16]}}, prod_s[i]};
        end
    end
endmodule

module conv_seq_ctrl #(
    parameter int IMG_H  = 8,
    parameter int IMG_W  = 8,
    parameter int K_H    = 3,
    parameter int K_W    = 3,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [K_H*K_W*8-1:0] w_flat,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [7:0]           mem_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [23:0]          out_data,
    output logic [7:0]           out_row,
    output logic [7:0]           out_col,
    output logic                 busy,
    output logic                 done
);
    localparam int OH = IMG_H - K_H + 1;
    localparam int OW = IMG_W - K_W + 1;
    localparam int NW = K_H * K_W * 8;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_CALC, S_OUT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    row_q, row_d, col_q, col_d;
    logic [7:0]    kr_q, kr_d, kc_q, kc_d;
    logic [NW-1:0] w_q, w_d;
    logic [23:0]   out_data_q, out_data_d;
    logic [7:0]    out_row_q, out_row_d, out_col_q, out_col_d;
    logic [NW-1:0] win_q;
    logic          cap_en_q;
    logic [7:0]    cap_r_q, cap_c_q;
    logic [23:0]   conv_s;
    logic          last_pos_s;

    conv_unit #(.K_H(K_H), .K_W(K_W)) u_conv (
        .pix_flat (win_q),
        .w_flat   (w_q),
        .result   (conv_s)
    );

    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign last_pos_s = (row_q == 8'(OH - 1)) && (col_q == 8'(OW - 1));

    // Sequencer state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= 8'd0;
            col_q      <= 8'd0;
            kr_q       <= 8'd0;
            kc_q       <= 8'd0;
            w_q        <= '0;
            out_data_q <= 24'd0;
            out_row_q  <= 8'd0;
            out_col_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            w_q        <= w_d;
            out_data_q <= out_data_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
        end
    end

    // Window capture: SRAM data lands one cycle after its read, so the slot index is delayed too
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_en_q <= 1'b0;
            cap_r_q  <= 8'd0;
            cap_c_q  <= 8'd0;
            win_q    <= '0;
        end else begin
            cap_en_q <= mem_rd_en;
            cap_r_q  <= kr_q;
            cap_c_q  <= kc_q;
            if (cap_en_q) begin
                win_q[(int'(cap_r_q) * K_W + int'(cap_c_q)) * 8 +: 8] <= mem_rd_data;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        kr_d       = kr_q;
        kc_d       = kc_q;
        w_d        = w_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        out_valid  = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d     = w_flat;
                    row_d   = 8'd0;
                    col_d   = 8'd0;
                    kr_d    = 8'd0;
                    kc_d    = 8'd0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = ADDR_W'((int'(row_q) + int'(kr_q)) * IMG_W + int'(col_q) + int'(kc_q));
                if (kc_q == 8'(K_W - 1)) begin
                    kc_d = 8'd0;
                    if (kr_q == 8'(K_H - 1)) begin
                        kr_d    = 8'd0;
                        state_d = S_DRAIN;
                    end else begin
                        kr_d = kr_q + 8'd1;
                    end
                end else begin
                    kc_d = kc_q + 8'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                out_data_d = conv_s;
                out_row_d  = row_q;
                out_col_d  = col_q;
                state_d    = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_pos_s) begin
                        state_d = S_DONE;
                    end else begin
                        if (col_q == 8'(OW - 1)) begin
                            col_d = 8'd0;
                            row_d = row_q + 8'd1;
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
